// File: rtl/bio_dma_arb_pkg.sv
// Shared types and AHB-lite constants for the BIO DMA round-robin arbiter.
package bio_dma_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HSIZE_MAX     = 3'd2;

    function automatic logic [2:0] clamp_size(input logic [2:0] s);
        return (s > HSIZE_MAX) ? HSIZE_MAX : s;
    endfunction

endpackage

// File: rtl/bio_rr_picker.sv
// Combinational round-robin picker: first requester at or after last+1 (mod NREQ).
module bio_rr_picker #(
    parameter int NREQ = 4,
    parameter int LW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [LW-1:0]   last,
    output logic            found,
    output logic [LW-1:0]   gnt
);

    logic [NREQ-1:0] rot;
    int              base;
    int              enc;

    // Rotate so the search start sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        base  = (int'(last) + 1) % NREQ;
        rot   = '0;
        found = 1'b0;
        enc   = 0;
        for (int i = 0; i < NREQ; i++) begin
            rot[i] = req[LW'((base + i) % NREQ)];
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                enc   = i;
            end
        end
        gnt = LW'((base + enc) % NREQ);
    end

endmodule

// File: rtl/bio_dma_arbiter.sv
// Round-robin arbiter + single-transfer AHB-lite sequencer for the BIO DMA master port.
// Optional bus locking is enabled with `define BIO_DMA_ARB_LOCK_EN.
module bio_dma_arbiter
    import bio_dma_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = 32,
    parameter int DW   = 32
) (
    input  logic              aclk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    input  logic [NREQ*3-1:0] size,
`ifdef BIO_DMA_ARB_LOCK_EN
    input  logic [NREQ-1:0]   lock,
`endif
    output logic [NREQ-1:0]   ack,
    output logic [DW-1:0]     rdata,
    output logic              err,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [AW-1:0]     haddr,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic              hmasterlock,
    output logic [DW-1:0]     hwdata,
    input  logic [DW-1:0]     hrdata,
    input  logic              hready,
    input  logic              hresp
);

    localparam int LW = $clog2(NREQ);

    arb_state_e     state_q, state_d;
    logic [LW-1:0]  gnt_q, gnt_d, last_q, last_d;
    logic           we_q, we_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [DW-1:0]  wdata_q, wdata_d;
    logic [2:0]     size_q, size_d;
`ifdef BIO_DMA_ARB_LOCK_EN
    logic           hold_q, hold_d;
    logic           mlock_q, mlock_d;
`endif

    logic [AW-1:0]  addr_a  [NREQ];
    logic [DW-1:0]  wdata_a [NREQ];
    logic [2:0]     size_a  [NREQ];
    logic           pick_found;
    logic [LW-1:0]  pick_gnt;
    logic [LW-1:0]  sel;
    logic           done;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addr_a[i]  = addr[i*AW +: AW];
        assign wdata_a[i] = wdata[i*DW +: DW];
        assign size_a[i]  = size[i*3 +: 3];
    end

    bio_rr_picker #(.NREQ(NREQ), .LW(LW)) u_picker (
        .req   (req),
        .last  (last_q),
        .found (pick_found),
        .gnt   (pick_gnt)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        sel     = pick_gnt;
`ifdef BIO_DMA_ARB_LOCK_EN
        hold_d  = hold_q;
        mlock_d = mlock_q;
        // A locked owner that still requests bypasses rotation.
        if (hold_q && req[gnt_q]) sel = gnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_ADDR;
                    gnt_d   = sel;
                    we_d    = we[sel];
                    addr_d  = addr_a[sel];
                    wdata_d = wdata_a[sel];
                    size_d  = clamp_size(size_a[sel]);
`ifdef BIO_DMA_ARB_LOCK_EN
                    last_d  = (hold_q && req[gnt_q]) ? last_q : sel;
                    mlock_d = lock[sel];
                    hold_d  = 1'b0;
`else
                    last_d  = sel;
`endif
                end
            end
            ST_ADDR: begin
                if (hready) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (hready) begin
                    state_d = ST_IDLE;
`ifdef BIO_DMA_ARB_LOCK_EN
                    hold_d  = lock[gnt_q];
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            last_q  <= LW'(NREQ - 1);
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
`ifdef BIO_DMA_ARB_LOCK_EN
            hold_q  <= 1'b0;
            mlock_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
`ifdef BIO_DMA_ARB_LOCK_EN
            hold_q  <= hold_d;
            mlock_q <= mlock_d;
`endif
        end
    end

    assign done   = (state_q == ST_DATA) && hready;
    assign htrans = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign haddr  = addr_q;
    assign hwrite = we_q;
    assign hsize  = size_q;
    assign hburst = HBURST_SINGLE;
    assign hwdata = ((state_q == ST_DATA) && we_q) ? wdata_q : '0;
    assign rdata  = done ? hrdata : '0;
    assign err    = done & hresp;
`ifdef BIO_DMA_ARB_LOCK_EN
    assign hmasterlock = (state_q == ST_ADDR) & mlock_q;
`else
    assign hmasterlock = 1'b0;
`endif

    always_comb begin
        ack = '0;
        if (done) ack[gnt_q] = 1'b1;
    end

endmodule

// File: tb/tb_bio_dma_arbiter.sv
// Scoreboard bench for bio_dma_arbiter: stimulus pushes expected acks, a monitor pops and checks them.
module tb_bio_dma_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;

    logic               aclk;
    logic               reset;
    logic [NREQ-1:0]    req, we;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ*3-1:0]  size;
    logic [NREQ-1:0]    ack;
    logic [DW-1:0]      rdata;
    logic               err;
    logic [1:0]         htrans;
    logic               hwrite;
    logic [AW-1:0]      haddr;
    logic [2:0]         hsize, hburst;
    logic               hmasterlock;
    logic [DW-1:0]      hwdata, hrdata;
    logic               hready, hresp;
`ifdef BIO_DMA_ARB_LOCK_EN
    logic [NREQ-1:0]    lock;
`endif

    bio_dma_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .aclk        (aclk),
        .reset       (reset),
        .req         (req),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .size        (size),
`ifdef BIO_DMA_ARB_LOCK_EN
        .lock        (lock),
`endif
        .ack         (ack),
        .rdata       (rdata),
        .err         (err),
        .htrans      (htrans),
        .hwrite      (hwrite),
        .haddr       (haddr),
        .hsize       (hsize),
        .hburst      (hburst),
        .hmasterlock (hmasterlock),
        .hwdata      (hwdata),
        .hrdata      (hrdata),
        .hready      (hready),
        .hresp       (hresp)
    );

    typedef struct {
        int          ch;
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   k;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic push(input int ch, input int c, input logic [31:0] rd, input logic e);
        exp_t x;
        x.ch = ch; x.cyc = c; x.rdata = rd; x.err = e;
        sb.push_back(x);
    endtask

    task automatic set_ch(input int ch, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] s);
        we[ch]          = w;
        addr[ch*AW +: AW] = a;
        wdata[ch*DW +: DW] = d;
        size[ch*3 +: 3]  = s;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        req = '0; we = '0; addr = '0; wdata = '0; size = '0;
        hready = 1'b1; hresp = 1'b0; hrdata = '0;
`ifdef BIO_DMA_ARB_LOCK_EN
        lock = '0;
`endif
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic drain;
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick;
        chk("sb_drain_pending", sb.size(), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_htrans"}, htrans, 0);
        chk({tag, "_haddr"}, haddr, 0);
        chk({tag, "_hwrite"}, hwrite, 0);
        chk({tag, "_hsize"}, hsize, 0);
        chk({tag, "_hburst"}, hburst, 0);
        chk({tag, "_hmasterlock"}, hmasterlock, 0);
        chk({tag, "_hwdata"}, hwdata, 0);
        chk({tag, "_ack"}, ack, 0);
        chk({tag, "_rdata"}, rdata, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // Monitor: every cycle with an ack must match the head of the scoreboard.
    always @(negedge aclk) begin
        if (ack != '0) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL ack_unexpected actual=%0h required=0 (cycle %0d)", ack, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ack_onehot", ack, 64'(1) << e.ch);
                chk("ack_cycle", cyc, e.cyc);
                chk("ack_rdata", rdata, e.rdata);
                chk("ack_err", err, e.err);
            end
        end
    end

    initial begin
        reset = 1'b1;
        req = '0; we = '0; addr = '0; wdata = '0; size = '0;
        hready = 1'b1; hresp = 1'b0; hrdata = '0;
`ifdef BIO_DMA_ARB_LOCK_EN
        lock = '0;
`endif
        tick;
        #3 chk_all_zero("reset");

        // Single read on channel 0.
        do_reset;
        k = cyc;
        set_ch(0, 1'b0, 32'h6000_0010, 32'h0, 3'd2);
        req = 4'b0001;
        hrdata = 32'hDEAD_BEEF;
        push(0, k + 2, 32'hDEAD_BEEF, 1'b0);
        tick;
        #3;
        chk("rd_htrans_c1", htrans, 2);
        chk("rd_haddr_c1", haddr, 32'h6000_0010);
        chk("rd_hwrite_c1", hwrite, 0);
        chk("rd_hsize_c1", hsize, 2);
        chk("rd_hmlock_c1", hmasterlock, 0);
        tick;
        #3 chk("rd_htrans_c2", htrans, 0);
        tick;
        req = '0;
        drain;

        // Round-robin with all channels requesting permanently.
        do_reset;
        k = cyc;
        for (int i = 0; i < NREQ; i++) set_ch(i, 1'b0, 32'h6000_1000 + 32'(i * 16), 32'h0, 3'd2);
        req = 4'b1111;
        hrdata = 32'hA5A5_0000 + 32'(cyc);
        push(0, k + 2,  32'hA5A5_0000 + 32'(k + 2),  1'b0);
        push(1, k + 5,  32'hA5A5_0000 + 32'(k + 5),  1'b0);
        push(2, k + 8,  32'hA5A5_0000 + 32'(k + 8),  1'b0);
        push(3, k + 11, 32'hA5A5_0000 + 32'(k + 11), 1'b0);
        push(0, k + 14, 32'hA5A5_0000 + 32'(k + 14), 1'b0);
        for (int c = 1; c <= 14; c++) begin
            tick;
            hrdata = 32'hA5A5_0000 + 32'(cyc);
            if (c == 7) begin
                #3 chk("rr_haddr_ch2", haddr, 32'h6000_1020);
            end
        end
        tick;
        req = '0;
        drain;

        // Write with wait states, mid-transfer payload change and oversize HSIZE.
        do_reset;
        k = cyc;
        set_ch(0, 1'b1, 32'h6000_0020, 32'h1234_5678, 3'd7);
        req = 4'b0001;
        hready = 1'b0;
        hrdata = 32'h0;
        push(0, k + 7, 32'h0, 1'b0);
        for (int c = 1; c <= 7; c++) begin
            tick;
            hready = (c == 3 || c == 7);
            if (c == 2) set_ch(0, 1'b0, 32'h0BAD_0000, 32'hFFFF_FFFF, 3'd0);
            #3;
            if (c <= 3) begin
                chk("ws_htrans_addr", htrans, 2);
                chk("ws_haddr", haddr, 32'h6000_0020);
                chk("ws_hwrite", hwrite, 1);
                chk("ws_hsize_clamp", hsize, 2);
            end else begin
                chk("ws_htrans_data", htrans, 0);
                chk("ws_hwdata", hwdata, 32'h1234_5678);
            end
        end
        tick;
        req = '0;
        hready = 1'b1;
        drain;

        // Error response: first error cycle silent, completion on the second.
        do_reset;
        k = cyc;
        set_ch(0, 1'b0, 32'h6000_0030, 32'h0, 3'd2);
        req = 4'b0001;
        hrdata = 32'h0000_00E1;
        push(0, k + 3, 32'h0000_00E1, 1'b1);
        tick;
        tick;
        hready = 1'b0;
        hresp = 1'b1;
        #3;
        chk("err_c1_ack", ack, 0);
        chk("err_c1_err", err, 0);
        tick;
        hready = 1'b1;
        tick;
        hresp = 1'b0;
        req = '0;
        drain;

        // Reset during DATA: everything clears at once, no ack, channel 0 wins afterwards.
        do_reset;
        k = cyc;
        for (int i = 0; i < NREQ; i++) set_ch(i, 1'b1, 32'h6000_2000 + 32'(i * 16), 32'hC0DE_0000 + 32'(i), 3'd2);
        req = 4'b0110;
        hrdata = 32'h5555_AAAA;
        tick;
        #3 chk("rst_pre_haddr_ch1", haddr, 32'h6000_2010);
        tick;
        #1 reset = 1'b1;
        #1 chk_all_zero("rst_mid");
        tick;
        req = 4'b0111;
        reset = 1'b0;
        k = cyc;
        push(0, k + 2, 32'h5555_AAAA, 1'b0);
        tick;
        #3 chk("rst_post_haddr_ch0", haddr, 32'h6000_2000);
        tick;
        tick;
        req = '0;
        drain;

`ifdef BIO_DMA_ARB_LOCK_EN
        // Locked channel 1 keeps the bus until lock drops.
        do_reset;
        k = cyc;
        set_ch(0, 1'b0, 32'h6000_3000, 32'h0, 3'd2);
        set_ch(1, 1'b0, 32'h6000_3010, 32'h0, 3'd2);
        req = 4'b0011;
        hrdata = 32'h1111_2222;
        push(0, k + 2,  32'h1111_2222, 1'b0);
        push(1, k + 5,  32'h1111_2222, 1'b0);
        push(1, k + 8,  32'h1111_2222, 1'b0);
        push(1, k + 11, 32'h1111_2222, 1'b0);
        push(0, k + 14, 32'h1111_2222, 1'b0);
        for (int c = 1; c <= 14; c++) begin
            tick;
            if (c == 4)  lock = 4'b0010;
            if (c == 10) lock = 4'b0000;
            #3;
            if (c == 4)  chk("lock_hml_first", hmasterlock, 0);
            if (c == 7)  chk("lock_hml_second", hmasterlock, 1);
            if (c == 10) chk("lock_hml_third", hmasterlock, 1);
            if (c == 13) chk("lock_hml_ch0", hmasterlock, 0);
        end
        tick;
        req = '0;
        drain;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bio_dma_arbiter.md
# bio_dma_arbiter

Round-robin arbiter and AHB-lite sequencer that shares the single BIO DMA AHB master port between `NREQ` requester channels (one per BIO core FIFO DMA engine). It accepts single-word read/write requests, grants one channel at a time, and runs one non-pipelined NONSEQ transfer per grant. It sits between the BIO cores' DMA request logic and the AHB master interface of `bio_bdma`.

## Interface
- `NREQ`, 4, number of requester channels (2..8)
- `AW`, 32, AHB address width
- `DW`, 32, data width
- `aclk`  in  1  block clock; all logic on the rising edge
- `reset`  in  1  reset, asynchronous and active-high
- `req`  in  NREQ  per-channel request; held with its payload until `ack`
- `we`  in  NREQ  1 = write, 0 = read
- `addr`  in  NREQ×AW  per-channel byte address
- `wdata`  in  NREQ×DW  per-channel write data
- `size`  in  NREQ×3  per-channel HSIZE (0, 1 or 2 only)
- `ack`  out  NREQ  one-hot completion strobe, combinational
- `rdata`  out  DW  read data, valid with `ack`
- `err`  out  1  error flag, valid with `ack`
- `htrans`, `hwrite`, `haddr`, `hsize`, `hburst`, `hmasterlock`, `hwdata`  out  AHB master outputs (2, 1, AW, 3, 3, 1, DW bits)
- `hrdata`, `hready`, `hresp`  in  AHB master inputs (DW, 1, 1 bits)

## Operation
- FSM states are IDLE, ADDR and DATA.
- IDLE
  - If any `req` is high, the `bio_rr_picker` selects the first requester at or after `last+1` (mod NREQ).
  - Register `gnt`, `last<=gnt`, and latch that channel's `we/addr/size/wdata` into the address/data registers.
  - Go to ADDR.
- ADDR
  - `htrans=2'b10` (NONSEQ), `haddr/hwrite/hsize` from the latch, `hburst=3'b000`.
  - On `hready=1`, go to DATA. Otherwise hold every output stable.
- DATA
  - `htrans=2'b00`. `hwdata` is driven from the latch for writes and is 0 for reads.
  - On `hready=1`: `ack[gnt]=1`, `rdata=hrdata`, `err=hresp`, then go to IDLE.
  - `hready=0` holds the state. During the first `hresp` error cycle (`hready=0`) nothing is signalled; completion occurs on the second cycle, with `err=1`.
- Requester rules
  - The requester drops or reloads `req` on the cycle after `ack`.
  - In IDLE a new arbitration happens, so a requester that keeps `req` high queues its next transfer behind the other requesters in round-robin order.
- When not in DATA with `hready=1`, `ack=0`, `rdata=0` and `err=0`.
- Payload changes while a transfer is granted are ignored, because the payload is latched in IDLE.
- A `size` greater than 2 is clamped to 2.
- `haddr` is passed through unaligned; alignment is the requester's responsibility.

## Timing
- Reset values:
  - FSM = IDLE, `last = NREQ-1` (channel 0 wins first).
  - `htrans=0`, `haddr=0`, `hwrite=0`, `hsize=0`, `hburst=0`, `hmasterlock=0`, `hwdata=0`, `ack=0`, `rdata=0`, `err=0`.
- Latency with zero wait states:
  - `req` sampled in IDLE at cycle 0 → ADDR in cycle 1 → DATA in cycle 2 with `ack` in cycle 2.
  - Throughput is one transfer per 3 cycles.
  - Each `hready=0` cycle adds one cycle.
- Simultaneous requests resolve strictly by round-robin. Pointer wrap-around: after channel NREQ-1 is granted, the search starts at channel 0.
- `reset` asserted mid-transfer returns to IDLE immediately with no `ack`. The aborted transfer is not replayed.

## Configuration
- `BIO_DMA_ARB_LOCK_EN` defined:
  - Adds input `lock` [NREQ].
  - If `lock[gnt]=1` when `ack` fires, the next IDLE grants `gnt` again without rotating `last`, provided its `req` is high.
  - `hmasterlock=1` during ADDR of every transfer whose `lock` was high when it was latched.
- `BIO_DMA_ARB_LOCK_EN` undefined:
  - The `lock` port is absent.
  - `hmasterlock` is tied to 0.
  - Behaviour is pure round-robin.

## Structure
- `bio_dma_arb_pkg` holds:
  - the FSM state enum;
  - the HTRANS constants IDLE/NONSEQ;
  - the HBURST SINGLE constant;
  - the HSIZE maximum (2).
- Sub-module `bio_rr_picker`: combinational, parameterised by `NREQ`.
  - Inputs: `req` vector and `last` index.
  - Outputs: `found` and `gnt` index.
  - Implemented as a rotate, priority-encode, rotate back.

## Test plan
- Single read
  - Stimulus: `req[0]`, `addr=0x6000_0010`, `hrdata=0xDEAD_BEEF`, `hready=1`.
  - Required: `htrans=2` in cycle 1; `ack[0]=1` with `rdata=0xDEAD_BEEF` in cycle 2.
- Round-robin
  - Stimulus: `req=4'b1111` held permanently.
  - Required: grants in order 0,1,2,3,0; each `ack` 3 cycles apart.
- Wait states
  - Stimulus: write `wdata=0x1234_5678`; `hready=0` for 2 ADDR cycles and 3 DATA cycles.
  - Required: `haddr/hwdata` stable throughout; `ack` in cycle 7.
- Error response
  - Stimulus: DATA cycles with `hresp=1,hready=0`, then `hresp=1,hready=1`.
  - Required: `ack` with `err=1` on the second cycle only.
- Reset mid-transfer
  - Stimulus: assert `reset` during DATA.
  - Required: all outputs 0 in the same cycle; no `ack`; first grant after release goes to channel 0.
- Lock (`BIO_DMA_ARB_LOCK_EN`)
  - Stimulus: `req=4'b0011`, `lock[1]=1` after channel 1's first grant.
  - Required: channel 1 is granted repeatedly with `hmasterlock=1`; channel 0 resumes once `lock[1]` drops.
